// File: rtl/fetch_stage_ctrl.sv
// IF-stage controller: program counter, IF/ID pipeline register, stall/redirect
// handling and saturating stall/flush statistics with a sticky long-stall flag.
module fetch_stage_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        idflush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        ctrl_bubble,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic        stall_err
);

  localparam logic [3:0] StallRunLimit = 4'd8;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [3:0]  run_q, run_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus4;
  logic        redirect;

  // Wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = !stall && (branch_taken || jump);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (stall) begin
      // Hold everything; redirects wait until the stall clears.
    end else if (branch_taken) begin
      pc_d    = branch_target;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (jump) begin
      pc_d    = jump_target;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_d       = '0;
    if (stall) begin
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      // Run counter saturates so very long stalls cannot wrap it.
      run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
    end
    if (redirect && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    err_d = err_q || (run_d == StallRunLimit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_q       <= run_d;
      err_q       <= err_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign ctrl_bubble = idflush || !valid_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign stall_err   = err_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: a reference model pushes expected outputs per
// driven cycle; they are popped and compared one step after the clock edge.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, idflush, branch_taken, jump;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic [31:0] pc_out, if_id_instr, if_id_pc4;
  logic        if_id_valid, ctrl_bubble, stall_err;
  logic [15:0] stall_count, flush_count;

  fetch_stage_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .idflush      (idflush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .ctrl_bubble  (ctrl_bubble),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .stall_err    (stall_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        bubble;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;
  logic [15:0] m_sc, m_fc;
  int unsigned m_run;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic [31:0] instr);
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_sc = 0; m_fc = 0; m_run = 0; m_err = 0;
    end else if (s) begin
      if (m_sc != 16'hFFFF) m_sc = m_sc + 1;
      m_run = (m_run < 15) ? m_run + 1 : 15;
      if (m_run == 8) m_err = 1;
    end else begin
      m_run = 0;
      if (b || j) begin
        if (m_fc != 16'hFFFF) m_fc = m_fc + 1;
        m_pc = b ? bt : jt;
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else begin
        m_instr = instr;
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc4;
        m_valid = 1;
      end
    end
  endtask

  task automatic cmp_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("pc_out", pc_out, e.pc);
    check_eq("if_id_instr", if_id_instr, e.instr);
    check_eq("if_id_pc4", if_id_pc4, e.pc4);
    check_eq("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
    check_eq("ctrl_bubble", {31'd0, ctrl_bubble}, {31'd0, e.bubble});
    check_eq("stall_count", {16'd0, stall_count}, {16'd0, e.sc});
    check_eq("flush_count", {16'd0, flush_count}, {16'd0, e.fc});
    check_eq("stall_err", {31'd0, stall_err}, {31'd0, e.err});
  endtask

  // Drive one cycle, push the model's expectation, and compare after the edge if chk.
  task automatic step(input logic r, input logic s, input logic fl, input logic b,
                      input logic [31:0] bt, input logic j, input logic [31:0] jt,
                      input logic [31:0] instr, input logic chk);
    exp_t e;
    reset = r; stall = s; idflush = fl; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; imem_rdata = instr;
    model_update(r, s, b, bt, j, jt, instr);
    e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, bubble: fl | ~m_valid,
          sc: m_sc, fc: m_fc, err: m_err};
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (chk) cmp_pop();
  endtask

  task automatic idle(input logic [31:0] instr);
    step(0, 0, 0, 0, 32'd0, 0, 32'd0, instr, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 1);
  endtask

  logic [31:0] saved_instr;
  logic [31:0] saved_pc4;

  initial begin
    reset = 1; stall = 0; idflush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0; imem_rdata = 0;
    m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_valid = 0; m_sc = 0; m_fc = 0; m_run = 0; m_err = 0;

    // Reset then sequential fetch
    do_reset();
    check_eq("rst_bubble", {31'd0, ctrl_bubble}, 32'd1);
    check_eq("rst_pc", pc_out, 32'h0);
    idle(32'h2008_0001);
    check_eq("seq1_pc4", if_id_pc4, 32'h4);
    check_eq("seq1_valid", {31'd0, if_id_valid}, 32'd1);
    idle(32'h2008_0001);
    idle(32'h2008_0001);
    check_eq("seq3_pc", pc_out, 32'hC);

    // idflush forces a bubble even with a valid IF/ID
    step(0, 0, 1, 0, 32'd0, 0, 32'd0, 32'h1111_2222, 1);
    check_eq("idflush_bubble", {31'd0, ctrl_bubble}, 32'd1);

    // Stall at pc 0x40 ignores a pending branch
    do_reset();
    for (int i = 0; i < 16; i++) idle(32'h0A00_0000 + i);
    check_eq("pre_stall_pc", pc_out, 32'h40);
    saved_instr = if_id_instr;
    saved_pc4   = if_id_pc4;
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1, 32'h900, 0, 32'd0, 32'hDEAD_BEEF, 1);
    check_eq("stall_pc_hold", pc_out, 32'h40);
    check_eq("stall_instr_hold", if_id_instr, saved_instr);
    check_eq("stall_pc4_hold", if_id_pc4, saved_pc4);
    check_eq("stall_cnt2", {16'd0, stall_count}, 32'd2);
    check_eq("stall_fc0", {16'd0, flush_count}, 32'd0);

    // Branch beats jump in the same cycle
    step(0, 0, 0, 1, 32'h100, 1, 32'h200, 32'h1234_5678, 1);
    check_eq("br_pc", pc_out, 32'h100);
    check_eq("br_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("br_bubble", {31'd0, ctrl_bubble}, 32'd1);
    check_eq("br_fc", {16'd0, flush_count}, 32'd1);
    step(0, 0, 0, 0, 32'd0, 1, 32'h0000_0203, 32'h0, 1);  // unaligned jump used as-is
    idle(32'h5555_AAAA);

    // PC wrap
    step(0, 0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC, 32'h0, 1);
    idle(32'hCAFE_0001);
    check_eq("wrap_pc", pc_out, 32'h0);
    check_eq("wrap_pc4", if_id_pc4, 32'h0);

    // Long stall sets the sticky error on the 8th cycle
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 32'd0, 0, 32'd0, 32'h0, 1);
    check_eq("err_after7", {31'd0, stall_err}, 32'd0);
    step(0, 1, 0, 0, 32'd0, 0, 32'd0, 32'h0, 1);
    check_eq("err_after8", {31'd0, stall_err}, 32'd1);
    idle(32'h7777_0000);
    idle(32'h7777_0004);
    check_eq("err_sticky", {31'd0, stall_err}, 32'd1);
    do_reset();
    check_eq("err_cleared", {31'd0, stall_err}, 32'd0);

    // A broken run of 7 + 7 stalls must not set the error
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 32'd0, 0, 32'd0, 32'h0, 1);
    idle(32'h0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 32'd0, 0, 32'd0, 32'h0, 1);
    check_eq("err_broken_run", {31'd0, stall_err}, 32'd0);

    // Stall counter saturation, then reset mid-stall
    do_reset();
    for (int i = 0; i < 65534; i++) step(0, 1, 0, 0, 32'd0, 0, 32'd0, 32'h0, 0);
    step(0, 1, 0, 0, 32'd0, 0, 32'd0, 32'h0, 1);
    check_eq("sat_ffff", {16'd0, stall_count}, 32'h0000_FFFF);
    step(0, 1, 0, 1, 32'h300, 0, 32'd0, 32'h0, 1);
    check_eq("sat_hold", {16'd0, stall_count}, 32'h0000_FFFF);
    step(1, 1, 0, 1, 32'h300, 1, 32'h400, 32'hFFFF_FFFF, 1);
    check_eq("rst_mid_sc", {16'd0, stall_count}, 32'd0);
    check_eq("rst_mid_pc", pc_out, 32'd0);
    check_eq("rst_mid_err", {31'd0, stall_err}, 32'd0);
    check_eq("rst_mid_bubble", {31'd0, ctrl_bubble}, 32'd1);
    idle(32'h0BAD_F00D);

    if (exp_q.size() != 0) check_eq("scoreboard_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage_ctrl.md
FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID this cycle
- idflush  input  1  hazard unit: bubble into ID/EX this cycle
- branch_taken  input  1  ID-stage resolved beq/bne taken
- branch_target  input  32  branch destination address
- jump  input  1  ID-stage decoded jump
- jump_target  input  32  jump destination address
- imem_rdata  input  32  instruction at pc_out (combinational memory)
- pc_out  output  32  current fetch address
- if_id_instr  output  32  registered IF/ID instruction
- if_id_pc4  output  32  registered IF/ID PC+4
- if_id_valid  output  1  IF/ID holds a real instruction
- ctrl_bubble  output  1  zero ID/EX control fields
- stall_count  output  16  saturating count of stalled cycles
- flush_count  output  16  saturating count of redirects
- stall_err  output  1  sticky: stall held too long

Function
REQ-003 SHALL update PC, IF/ID and counters only on rising clk.
REQ-004 SHALL apply per-cycle priority: reset > stall > branch_taken > jump > sequential fetch.
REQ-005 SHALL, with stall=1, hold pc_out, if_id_instr, if_id_pc4 and if_id_valid unchanged, ignoring branch_taken and jump.
REQ-006 SHALL, with stall=0 and branch_taken=1:
- load pc_out <= branch_target.
- load if_id_instr <= 0, if_id_pc4 <= 0, if_id_valid <= 0.
REQ-007 SHALL, with stall=0, branch_taken=0 and jump=1:
- load pc_out <= jump_target.
- bubble IF/ID as in REQ-006.
REQ-008 SHALL, otherwise:
- load pc_out <= pc_out+4.
- load if_id_instr <= imem_rdata, if_id_pc4 <= pc_out+4, if_id_valid <= 1.
REQ-009 SHALL compute pc_out+4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-010 SHALL drive ctrl_bubble combinationally as idflush OR NOT if_id_valid.
REQ-011 SHALL increment stall_count by 1 in each cycle with stall=1, saturating at 0xFFFF.
REQ-012 SHALL increment flush_count by 1 in each cycle with stall=0 and (branch_taken OR jump), saturating at 0xFFFF.
REQ-013 SHALL count consecutive stall=1 cycles in a 4-bit run counter, cleared in any cycle with stall=0.
REQ-014 SHALL set stall_err when the run counter reaches 8; stall_err stays set until reset.
REQ-015 SHALL have fetch-to-IF/ID latency of exactly 1 cycle; redirect takes effect at pc_out on the next edge.
REQ-016 SHALL use target addresses as given, with no alignment check or masking.

Reset
REQ-017 SHALL, when reset=1 at an edge, clear the following regardless of other inputs, including mid-stall or mid-redirect:
- pc_out=0x00000000, if_id_instr=0, if_id_pc4=0, if_id_valid=0.
- stall_count=0, flush_count=0, run counter=0, stall_err=0.
REQ-018 SHALL drive ctrl_bubble=1 immediately after reset, since if_id_valid=0.

Verification
REQ-019 SHALL cover these directed scenarios:
- Reset, then 3 idle cycles with imem_rdata=0x20080001 -> pc_out 0,4,8,12; if_id_valid=1 and if_id_pc4=4 after the first edge.
- pc_out=0x40, stall=1 for 2 cycles with branch_taken=1 -> pc_out stays 0x40, IF/ID unchanged, stall_count=2, flush_count=0.
- branch_taken=1, branch_target=0x100, jump=1, jump_target=0x200 in the same cycle -> pc_out=0x100, if_id_valid=0, ctrl_bubble=1, flush_count+1.
- pc_out=0xFFFFFFFC, no stall -> pc_out=0x00000000, if_id_pc4=0x00000000.
- stall=1 for 8 cycles -> stall_err=1 after the 8th edge; it stays 1 after stall drops and clears only on reset.
- reset=1 while stall=1 and stall_count=0xFFFF -> all outputs at REQ-017 values after the edge; separately, 0xFFFF plus a further stall stays 0xFFFF.
